// File: rtl/eeprom_prgm_loader.sv
// eeprom_prgm_loader
// Copies words 0..LAST_ADDR from an I2C EEPROM reader into program RAM
// while holding the CPU. Each word read is retried after a NACK or a
// timeout; the load aborts once the retries for a word run out.
//
// Ports
//   CLK, RESET          clock, synchronous active-high reset
//   GO, LAST_ADDR       start request and final word address (latched on GO)
//   RD_REQ, WORD_ADDR   one-cycle read strobe and word address to the reader
//   RD_DONE, RD_ERR     reader completion / NACK pulses
//   EEPROM_DATA         byte returned with RD_DONE
//   RAM_ADDR, RAM_DATA  program RAM write address and data
//   RAM_WE              one-cycle RAM write enable
//   HLT                 CPU hold (low only after a completed load)
//   BUSY                load in progress
//   DONE, ERR           sticky completion / failure flags
//   CHECKSUM            mod-256 sum of the bytes written by this load
module eeprom_prgm_loader #(
  parameter int unsigned TIMEOUT_CYCLES = 1023,
  parameter int unsigned RETRIES        = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       GO,
  input  logic [3:0] LAST_ADDR,
  output logic       RD_REQ,
  output logic [3:0] WORD_ADDR,
  input  logic       RD_DONE,
  input  logic       RD_ERR,
  input  logic [7:0] EEPROM_DATA,
  output logic [3:0] RAM_ADDR,
  output logic [7:0] RAM_DATA,
  output logic       RAM_WE,
  output logic       HLT,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [7:0] CHECKSUM
);

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned RW = (RETRIES > 0) ? $clog2(RETRIES + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WRITE,
    S_FIN,
    S_FAIL
  } state_t;

  state_t        state;
  logic [AW-1:0] addr;
  logic [AW-1:0] last;
  logic [TW-1:0] timer;
  logic [RW-1:0] retry;

  // Loader FSM; all outputs are registered and change together with the state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= S_IDLE;
      addr      <= '0;
      last      <= '0;
      timer     <= '0;
      retry     <= '0;
      RD_REQ    <= 1'b0;
      WORD_ADDR <= '0;
      RAM_ADDR  <= '0;
      RAM_DATA  <= '0;
      RAM_WE    <= 1'b0;
      HLT       <= 1'b1;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      ERR       <= 1'b0;
      CHECKSUM  <= '0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      RD_REQ <= 1'b0;
      RAM_WE <= 1'b0;

      case (state)
        S_IDLE, S_FIN, S_FAIL: begin
          if (GO) begin
            addr      <= '0;
            retry     <= '0;
            last      <= LAST_ADDR;
            CHECKSUM  <= '0;
            DONE      <= 1'b0;
            ERR       <= 1'b0;
            HLT       <= 1'b1;
            BUSY      <= 1'b1;
            RD_REQ    <= 1'b1;
            WORD_ADDR <= '0;
            state     <= S_REQ;
          end
        end

        S_REQ: begin
          timer <= '0;
          state <= S_WAIT;
        end

        S_WAIT: begin
          timer <= TW'(timer + 1'b1);
          // An error pulse wins over a simultaneous completion.
          if (RD_ERR || (!RD_DONE && (timer == TW'(TIMEOUT_CYCLES)))) begin
            if (retry < RW'(RETRIES)) begin
              retry     <= RW'(retry + 1'b1);
              RD_REQ    <= 1'b1;
              WORD_ADDR <= addr;
              state     <= S_REQ;
            end else begin
              ERR   <= 1'b1;
              HLT   <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_FAIL;
            end
          end else if (RD_DONE) begin
            // RAM_DATA doubles as the latched byte for the checksum.
            RAM_DATA <= EEPROM_DATA;
            RAM_ADDR <= addr;
            RAM_WE   <= 1'b1;
            state    <= S_WRITE;
          end
        end

        S_WRITE: begin
          CHECKSUM <= DW'(CHECKSUM + RAM_DATA);
          if (addr == last) begin
            DONE  <= 1'b1;
            HLT   <= 1'b0;
            BUSY  <= 1'b0;
            state <= S_FIN;
          end else begin
            addr      <= AW'(addr + 1'b1);
            retry     <= '0;
            RD_REQ    <= 1'b1;
            WORD_ADDR <= AW'(addr + 1'b1);
            state     <= S_REQ;
          end
        end

        default: begin
          HLT   <= 1'b1;
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eeprom_prgm_loader.sv
// Scoreboard bench for eeprom_prgm_loader: a reader model answers each
// RD_REQ from a planned list of attempt outcomes; the plan also yields the
// expected read addresses, RAM writes, checksum and final status.
module tb_eeprom_prgm_loader;

  localparam int unsigned T = 20;
  localparam int unsigned R = 2;

  localparam int K_OK   = 0;
  localparam int K_ERR  = 1;
  localparam int K_BOTH = 2;
  localparam int K_NONE = 3;

  typedef struct {
    int         kind;
    int         dly;
    logic [7:0] data;
  } act_t;

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       CLK;
  logic       RESET;
  logic       GO;
  logic [3:0] LAST_ADDR;
  logic       RD_REQ;
  logic [3:0] WORD_ADDR;
  logic       RD_DONE;
  logic       RD_ERR;
  logic [7:0] EEPROM_DATA;
  logic [3:0] RAM_ADDR;
  logic [7:0] RAM_DATA;
  logic       RAM_WE;
  logic       HLT;
  logic       BUSY;
  logic       DONE;
  logic       ERR;
  logic [7:0] CHECKSUM;

  eeprom_prgm_loader #(.TIMEOUT_CYCLES(T), .RETRIES(R)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .GO          (GO),
    .LAST_ADDR   (LAST_ADDR),
    .RD_REQ      (RD_REQ),
    .WORD_ADDR   (WORD_ADDR),
    .RD_DONE     (RD_DONE),
    .RD_ERR      (RD_ERR),
    .EEPROM_DATA (EEPROM_DATA),
    .RAM_ADDR    (RAM_ADDR),
    .RAM_DATA    (RAM_DATA),
    .RAM_WE      (RAM_WE),
    .HLT         (HLT),
    .BUSY        (BUSY),
    .DONE        (DONE),
    .ERR         (ERR),
    .CHECKSUM    (CHECKSUM)
  );

  act_t       act_q[$];
  wr_t        exp_wr_q[$];
  int         exp_req_q[$];
  int         req_cyc[$];
  int         passed = 0;
  int         total  = 0;
  int         cyc    = 0;
  int         stray_cnt = 0;
  logic [7:0] exp_sum;
  bit         exp_err;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, exp);
  endtask

  // Reference model: one planned read attempt and its consequences.
  task automatic add_attempt(input int a, input int kind, input int dly, input logic [7:0] d);
    act_t x;
    wr_t  w;
    x.kind = kind;
    x.dly  = dly;
    x.data = d;
    act_q.push_back(x);
    exp_req_q.push_back(a);
    if (kind == K_OK) begin
      w.addr = 4'(a);
      w.data = d;
      exp_wr_q.push_back(w);
      exp_sum = 8'(exp_sum + d);
    end
  endtask

  // Random plan: each word gets attempts until one succeeds or R+1 fail.
  task automatic plan_random(input int last);
    int tries;
    int r;
    int kind;
    for (int a = 0; a <= last; a++) begin
      tries = 0;
      forever begin
        r = int'($urandom_range(0, 9));
        kind = (r <= 5) ? K_OK : (r == 7) ? K_BOTH : (r == 8) ? K_NONE : K_ERR;
        add_attempt(a, kind, int'($urandom_range(1, T)), 8'($urandom));
        if (kind == K_OK) break;
        tries++;
        if (tries > R) begin
          exp_err = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic execute(input int last, input bit busy_go);
    int n;
    LAST_ADDR = 4'(last);
    GO = 1'b1;
    @(posedge CLK); #1;
    GO = 1'b0;
    chk("go_rd_req", RD_REQ, 1);
    chk("go_busy", BUSY, 1);
    chk("go_done_clr", DONE, 0);
    chk("go_err_clr", ERR, 0);
    chk("go_hlt", HLT, 1);
    LAST_ADDR = 4'($urandom);
    n = 0;
    while (!(DONE || ERR) && n < 5000) begin
      @(posedge CLK); #1;
      n++;
      if (busy_go && n == 7 && BUSY) begin
        GO = 1'b1;
        LAST_ADDR = 4'($urandom);
        @(posedge CLK); #1;
        GO = 1'b0;
        n++;
      end
    end
    chk("load_bounded", 32'(n < 5000), 1);
    chk("end_done", DONE, 32'(!exp_err));
    chk("end_err", ERR, 32'(exp_err));
    chk("end_hlt", HLT, 32'(exp_err));
    chk("end_busy", BUSY, 0);
    chk("end_checksum", CHECKSUM, exp_sum);
    chk("writes_left", exp_wr_q.size(), 0);
    chk("reqs_left", exp_req_q.size(), 0);
    chk("acts_left", act_q.size(), 0);
  endtask

  // Monitor: pops expected read addresses and RAM writes as the DUT presents them.
  always @(negedge CLK) begin : monitor
    wr_t w;
    if (!RESET) begin
      if (RAM_WE) begin
        if (exp_wr_q.size() == 0) chk("unexpected_ram_we", 1, 0);
        else begin
          w = exp_wr_q.pop_front();
          chk("ram_addr", RAM_ADDR, w.addr);
          chk("ram_data", RAM_DATA, w.data);
        end
      end
      if (RD_REQ) begin
        req_cyc.push_back(cyc);
        if (exp_req_q.size() == 0) chk("unexpected_rd_req", 1, 0);
        else chk("word_addr", WORD_ADDR, exp_req_q.pop_front());
      end
    end
  end

  // Reader model: serves each RD_REQ with the next planned outcome.
  initial begin : reader
    act_t x;
    int   seen;
    seen = 0;
    RD_DONE = 1'b0;
    RD_ERR = 1'b0;
    EEPROM_DATA = 8'h00;
    forever begin
      @(posedge CLK); #1;
      if (stray_cnt != seen) begin
        seen = stray_cnt;
        RD_DONE = 1'b1;
        EEPROM_DATA = 8'hC3;
        @(posedge CLK); #1;
        RD_DONE = 1'b1;
        RD_ERR = 1'b1;
        @(posedge CLK); #1;
        RD_DONE = 1'b0;
        RD_ERR = 1'b0;
      end
      while (RD_REQ && !RESET) begin
        if (act_q.size() == 0) begin
          chk("reader_underflow", 1, 0);
          break;
        end
        x = act_q.pop_front();
        if (x.kind == K_NONE) break;
        repeat (x.dly) @(posedge CLK);
        #1;
        RD_DONE = (x.kind == K_OK) || (x.kind == K_BOTH);
        RD_ERR = (x.kind != K_OK);
        EEPROM_DATA = x.data;
        @(posedge CLK); #1;
        RD_DONE = 1'b0;
        RD_ERR = 1'b0;
        EEPROM_DATA = 8'($urandom);
      end
    end
  end

  initial begin : main
    logic [7:0] b040 [4];
    int         n;
    b040 = '{8'h55, 8'hAA, 8'h01, 8'hFF};
    RESET = 1'b1;
    GO = 1'b0;
    LAST_ADDR = 4'h0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_rd_req", RD_REQ, 0);
    chk("rst_ram_we", RAM_WE, 0);
    chk("rst_word_addr", WORD_ADDR, 0);
    chk("rst_ram_addr", RAM_ADDR, 0);
    chk("rst_ram_data", RAM_DATA, 0);
    chk("rst_checksum", CHECKSUM, 0);
    chk("rst_flags", {DONE, ERR, BUSY, HLT}, 4'b0001);
    RESET = 1'b0;
    @(posedge CLK); #1;

    // Four words with fixed bytes and 5-cycle reader latency.
    exp_sum = 8'h00; exp_err = 1'b0;
    for (int a = 0; a < 4; a++) add_attempt(a, K_OK, 5, b040[a]);
    execute(3, 1'b0);
    chk("d040_checksum", CHECKSUM, 8'hFF);

    // Reader pulses while not waiting must not disturb FIN.
    stray_cnt++;
    repeat (6) @(posedge CLK);
    #1;
    chk("stray_done_held", DONE, 1);
    chk("stray_checksum_held", CHECKSUM, 8'hFF);

    // NACK on the first attempt at address 2, then success.
    exp_sum = 8'h00; exp_err = 1'b0;
    add_attempt(0, K_OK, 2, 8'h10);
    add_attempt(1, K_OK, 3, 8'h20);
    add_attempt(2, K_ERR, 4, 8'h00);
    add_attempt(2, K_OK, 1, 8'h30);
    add_attempt(3, K_OK, T, 8'h40);
    execute(3, 1'b0);

    // Simultaneous done and error counts as a failed attempt.
    exp_sum = 8'h00; exp_err = 1'b0;
    add_attempt(0, K_BOTH, 3, 8'h77);
    add_attempt(0, K_OK, 2, 8'h66);
    add_attempt(1, K_OK, 2, 8'h99);
    execute(1, 1'b0);

    // Reader never answers: R+1 attempts at address 0, each WAIT runs T+1 cycles.
    exp_sum = 8'h00; exp_err = 1'b0;
    for (int i = 0; i <= int'(R); i++) add_attempt(0, K_NONE, 0, 8'h00);
    exp_err = 1'b1;
    req_cyc.delete();
    execute(2, 1'b0);
    chk("timeout_req_count", req_cyc.size(), R + 1);
    for (int i = 1; i < req_cyc.size(); i++)
      chk("timeout_interval", req_cyc[i] - req_cyc[i-1], T + 2);

    // Reset while waiting on address 5.
    exp_sum = 8'h00; exp_err = 1'b0;
    for (int a = 0; a < 5; a++) add_attempt(a, K_OK, int'($urandom_range(1, T)), 8'($urandom));
    add_attempt(5, K_NONE, 0, 8'h00);
    LAST_ADDR = 4'd8;
    GO = 1'b1;
    @(posedge CLK); #1;
    GO = 1'b0;
    n = 0;
    while (exp_req_q.size() != 0 && n < 2000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("reset_reach_addr5", 32'(n < 2000), 1);
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_pre_busy", BUSY, 1);
    RESET = 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    chk("reset_mid_hlt", HLT, 1);
    chk("reset_mid_busy", BUSY, 0);
    chk("reset_mid_we", RAM_WE, 0);
    chk("reset_mid_checksum", CHECKSUM, 0);
    chk("reset_mid_writes_left", exp_wr_q.size(), 0);
    repeat (3) @(posedge CLK);
    #1;
    exp_sum = 8'h00; exp_err = 1'b0;
    for (int a = 0; a < 3; a++) add_attempt(a, K_OK, int'($urandom_range(1, T)), 8'($urandom));
    execute(2, 1'b0);

    // Full 16-word load with a GO while busy.
    exp_sum = 8'h00; exp_err = 1'b0;
    for (int a = 0; a < 16; a++) add_attempt(a, K_OK, int'($urandom_range(1, T)), 8'($urandom));
    execute(15, 1'b1);
    chk("full_last_ram_addr", RAM_ADDR, 4'hF);

    // Randomized loads back to back; each GO arrives in FIN or FAIL.
    for (int i = 0; i < 8; i++) begin
      exp_sum = 8'h00; exp_err = 1'b0;
      plan_random(int'($urandom_range(0, 15)));
      execute(int'($urandom_range(0, 15)) * 0 + int'(exp_req_q[exp_req_q.size()-1]) +
              (exp_err ? int'($urandom_range(0, 15 - exp_req_q[exp_req_q.size()-1])) : 0), 1'b1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/eeprom_prgm_loader.md
EEPROM_PRGM_LOADER -- requirements
Module: eeprom_prgm_loader

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1023: max cycles spent in WAIT per read attempt.
REQ-002 Parameter RETRIES, default 2: extra read attempts per word after NACK or timeout.
REQ-003 CLK  input  1  sole clock; all state changes on rising edge.
REQ-004 RESET  input  1  synchronous, active-high reset.
REQ-005 GO  input  1  debounced start request; sampled high in IDLE, DONE or ERROR.
REQ-006 LAST_ADDR  input  4  final word address to load; latched when GO is accepted.
REQ-007 RD_REQ  output  1  one-cycle read strobe to the I2C EEPROM reader.
REQ-008 WORD_ADDR  output  4  EEPROM word address; stable from RD_REQ until the attempt ends.
REQ-009 RD_DONE  input  1  reader completion pulse; EEPROM_DATA valid in the same cycle.
REQ-010 RD_ERR  input  1  reader NACK/abort pulse.
REQ-011 EEPROM_DATA  input  8  byte returned by the reader.
REQ-012 RAM_ADDR  output  4  program RAM write address.
REQ-013 RAM_DATA  output  8  program RAM write data.
REQ-014 RAM_WE  output  1  one-cycle RAM write enable.
REQ-015 HLT  output  1  holds the PC/CPU while loading or after failure.
REQ-016 BUSY  output  1  high in REQ, WAIT, WRITE.
REQ-017 DONE  output  1  sticky: load completed.
REQ-018 ERR  output  1  sticky: load aborted after retries exhausted.
REQ-019 CHECKSUM  output  8  mod-256 sum of all bytes written this load.

Function
REQ-020 States: IDLE, REQ, WAIT, WRITE, FIN, FAIL; encoding is free.
REQ-021 IDLE/FIN/FAIL with GO=1: addr<=0, retry<=0, CHECKSUM<=0, DONE<=0, ERR<=0, latch LAST_ADDR, go to REQ.
REQ-022 GO is ignored while BUSY=1.
REQ-023 REQ: RD_REQ=1 for exactly this cycle, WORD_ADDR=addr, timer<=0; next state WAIT.
REQ-024 WAIT: timer increments every cycle; RD_REQ=0.
REQ-025 WAIT with RD_DONE=1 and RD_ERR=0: latch EEPROM_DATA, go to WRITE.
REQ-026 WAIT with RD_ERR=1, or timer==TIMEOUT_CYCLES without RD_DONE: failed attempt.
REQ-027 RD_DONE and RD_ERR in the same cycle: treated as failed attempt (error wins).
REQ-028 Failed attempt with retry<RETRIES: retry+1, back to REQ (same addr); else go to FAIL.
REQ-029 WRITE: RAM_WE=1 this cycle only, RAM_ADDR=addr, RAM_DATA=latched byte, CHECKSUM<=CHECKSUM+byte (carry discarded).
REQ-030 WRITE with addr==latched LAST_ADDR: go to FIN; else addr+1, retry<=0, go to REQ.
REQ-031 No address wrap: LAST_ADDR=15 loads exactly 16 words, then FIN.
REQ-032 Latency: GO accepted at edge n -> RD_REQ high cycle n+1; RD_DONE in cycle k -> RAM_WE high cycle k+1; next RD_REQ cycle k+2.
REQ-033 FIN: DONE=1, HLT=0, BUSY=0. FAIL: ERR=1, HLT=1, BUSY=0.
REQ-034 HLT=1 in IDLE, REQ, WAIT, WRITE, FAIL.
REQ-035 RD_DONE/RD_ERR outside WAIT are ignored.
REQ-036 RAM_ADDR/RAM_DATA hold last written values when RAM_WE=0.

Reset
REQ-037 RESET=1 at a rising edge forces IDLE from any state, including mid-read or mid-write.
REQ-038 Reset values: RD_REQ=0, RAM_WE=0, WORD_ADDR=0, RAM_ADDR=0, RAM_DATA=0, CHECKSUM=0, DONE=0, ERR=0, BUSY=0, HLT=1, timer=0, retry=0.
REQ-039 RESET has priority over GO in the same cycle; a read abandoned by reset produces no RAM_WE.

Verification
REQ-040 LAST_ADDR=3, GO, reader returns 8'h55,8'hAA,8'h01,8'hFF after 5 cycles each -> RAM_WE 4 times at addr 0..3 with those bytes, CHECKSUM=8'hFF, DONE=1, HLT=0.
REQ-041 RD_ERR on first attempt of addr 2, success on retry -> two RD_REQ at WORD_ADDR=2, load completes, ERR=0.
REQ-042 RD_DONE never asserted, RETRIES=2 -> exactly 3 RD_REQ at addr 0, each WAIT ends after TIMEOUT_CYCLES, then ERR=1, HLT=1, no RAM_WE.
REQ-043 RD_DONE and RD_ERR same cycle -> no RAM_WE, retry issued for same address.
REQ-044 RESET asserted during WAIT at addr 5 -> next cycle IDLE, HLT=1, BUSY=0, no RAM_WE; subsequent GO restarts at addr 0.
REQ-045 LAST_ADDR=15 full load -> 16 writes, addr 15 last, DONE=1; GO while BUSY has no effect; GO in FIN restarts with DONE cleared.
